// File: rtl/oclib_pkg.sv
// Shared byte-channel types for the oclib block library, plus the state
// encoding and pointer sizing helper used by the async byte-channel slave.
package oclib_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } bc_8b_s;

  typedef struct packed {
    logic ready;
  } bc_8b_fb_s;

  typedef struct packed {
    logic [7:0] data;
    logic       req;
  } bc_async_8b_s;

  typedef struct packed {
    logic ack;
  } bc_async_8b_fb_s;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ACK_HIGH = 1'b1
  } bc_async_slave_state_e;

  // A one-entry FIFO still needs a 1-bit pointer.
  function automatic int bc_ptr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/oclib_bc_async_slave_chk.sv
// Simulation-only invariants of the async slave output FIFO and ack generation.
module oclib_bc_async_slave_chk #(
  parameter int FifoDepth = 2,
  parameter int CntW      = 2
) (
  input logic            clock,
  input logic            resetn,
  input logic            push_i,
  input logic            pop_i,
  input logic [CntW-1:0] count_i,
  input logic            ack_rise_i
);

  localparam logic [CntW-1:0] Full = CntW'(FifoDepth);

  a_no_underflow: assert property (@(posedge clock) disable iff (!resetn)
    !(pop_i && (count_i == CntW'(0))));

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push_i && !pop_i && (count_i == Full)));

  a_count_range: assert property (@(posedge clock) disable iff (!resetn)
    (count_i <= Full));

  a_ack_not_full: assert property (@(posedge clock) disable iff (!resetn)
    !(ack_rise_i && (count_i == Full)));

endmodule

// File: rtl/oclib_synchronizer.sv
// Multi-flop synchronizer for signals arriving from an unrelated clock domain.
module oclib_synchronizer #(
  parameter int Width      = 1,
  parameter int SyncCycles = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [SyncCycles-1:0][Width-1:0] sync_q;

  // Shift chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {(SyncCycles*Width){1'b0}};
    end else begin
      sync_q <= {sync_q[SyncCycles-2:0], d_i};
    end
  end

  assign q_o = sync_q[SyncCycles-1];

endmodule

// File: rtl/oclib_bc_async_slave.sv
// Receive end of the 4-phase asynchronous byte channel; re-issues each byte
// on a local valid/ready stream through a small registered-output FIFO.
module oclib_bc_async_slave
  import oclib_pkg::*;
#(
  parameter int SyncCycles = 3,
  parameter int FifoDepth  = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  bc_async_8b_s    bcIn,
  output bc_async_8b_fb_s bcInFb,
  output bc_8b_s          bcOut,
  input  bc_8b_fb_s       bcOutFb
);

  localparam int PtrW = bc_ptr_width(FifoDepth);
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] Full    = CntW'(FifoDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);

  logic                  req_sync_s;
  bc_async_slave_state_e state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  push_s, pop_s, head_from_din_s;
  logic [CntW:0]         occ_s;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]            mem_q [FifoDepth];
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    if (p == LastPtr) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  oclib_synchronizer #(
    .Width      (1),
    .SyncCycles (SyncCycles)
  ) u_req_sync (
    .clock  (clock),
    .resetn (resetn),
    .d_i    (bcIn.req),
    .q_o    (req_sync_s)
  );

  // The pending transfer counts against space so ack never promises a slot we lack.
  assign occ_s = {1'b0, count_q} + {{CntW{1'b0}}, (state_q == ACK_HIGH)};
  assign pop_s = out_valid_q & bcOutFb.ready;

  // Handshake FSM: next state, ack and FIFO push.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_sync_s && (occ_s < {1'b0, Full})) begin
          ack_d   = 1'b1;
          state_d = ACK_HIGH;
        end else begin
          ack_d = 1'b0;
        end
      end
      ACK_HIGH: begin
        if (!req_sync_s) begin
          push_s  = 1'b1;
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and the next value of the registered head.
  always_comb begin
    wr_ptr_d = push_s ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_next(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    head_from_din_s = push_s && ((count_q == CntW'(0)) ||
                                 (pop_s && (count_q == CntW'(1))));
    if (count_d == CntW'(0)) begin
      out_valid_d = 1'b0;
      out_data_d  = 8'h00;
    end else if (head_from_din_s) begin
      out_valid_d = 1'b1;
      out_data_d  = bcIn.data;
    end else begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_d];
    end
  end

  // State, ack and FIFO registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      count_q     <= {CntW{1'b0}};
      wr_ptr_q    <= {PtrW{1'b0}};
      rd_ptr_q    <= {PtrW{1'b0}};
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= bcIn.data;
      end
    end
  end

  assign bcInFb = bc_async_8b_fb_s'{ack: ack_q};
  assign bcOut  = bc_8b_s'{data: out_data_q, valid: out_valid_q};

  oclib_bc_async_slave_chk #(
    .FifoDepth (FifoDepth),
    .CntW      (CntW)
  ) u_chk (
    .clock      (clock),
    .resetn     (resetn),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .count_i    (count_q),
    .ack_rise_i (ack_d & ~ack_q)
  );

endmodule
